muldiv_unit: RTL



---
 rtl/mips_pkg.sv | 30 +++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit_step.sv | 60 ++++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
// Build option: MULDIV_DIV_EN enables the divide datapath.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_LOAD,
        MD_RUN,
        MD_FIX
    } md_state_e;

    typedef enum logic {
        MD_STEP_MUL,
        MD_STEP_DIV
    } md_step_e;

    localparam int unsigned MD_ITER = 32;

    function automatic logic md_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side request/result bundle for muldiv_unit.
// Build option: MULDIV_DIV_EN (no effect on the interface itself).
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit_step.sv
// One combinational shift-add (multiply) or restoring-subtract (divide) iteration.
// Build option: MULDIV_DIV_EN compiles the divide path.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    input  md_step_e         mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;

    always_comb begin
        sub = 1'b0;
        x   = acc;
        y   = shreg[0] ? operand : '0;
`ifdef MULDIV_DIV_EN
        if (mode == MD_STEP_DIV) begin
            sub = 1'b1;
            x   = {acc[WIDTH-2:0], shreg[WIDTH-1]};
            y   = ~operand;
        end
`endif
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, sub};

    always_comb begin
        acc_next   = {sum[WIDTH], sum[WIDTH-1:1]};
        shreg_next = {sum[0], shreg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // The shifted-out acc MSB means the partial remainder already exceeds the divisor.
        if (mode == MD_STEP_DIV) begin
            if (acc[WIDTH-1] || sum[WIDTH]) begin
                acc_next   = sum[WIDTH-1:0];
                shreg_next = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = x;
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
            end
        end
`else
    end

    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO writes.
// Build option: MULDIV_DIV_EN enables DIV/DIVU; without it divide requests are ignored.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_ITER
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave md
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, mq_q, opnd_q, hi_q, lo_q;
    logic             neg_lo_q, busy_q, done_q;
    logic             accept, start_ok, is_signed;
    logic [WIDTH-1:0] abs_a, abs_b, acc_nx, mq_nx, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    md_step_e         step_mode;

`ifdef MULDIV_DIV_EN
    logic is_div, neg_hi_q, div0_q;
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign start_ok  = 1'b1;
    assign step_mode = is_div ? MD_STEP_DIV : MD_STEP_MUL;
`else
    assign start_ok  = ~md.op[1];
    assign step_mode = MD_STEP_MUL;
`endif

    assign is_signed = md_is_signed(op_q);
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc        (acc_q),
        .shreg      (mq_q),
        .operand    (opnd_q),
        .mode       (step_mode),
        .acc_next   (acc_nx),
        .shreg_next (mq_nx)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md.start && start_ok) begin
                    state_d = MD_LOAD;
                    accept  = 1'b1;
                end
            end
            MD_LOAD: state_d = MD_RUN;
            MD_RUN:  if (cnt_q == CntLast) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        prod   = neg_lo_q ? -{acc_q, mq_q} : {acc_q, mq_q};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        // Remainder magnitude equals |a| when dividing by zero, so HI = a falls out naturally.
        if (is_div) begin
            res_lo = div0_q ? '1 : (neg_lo_q ? -mq_q : mq_q);
            res_hi = neg_hi_q ? -acc_q : acc_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MULT;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != MD_IDLE);
            done_q  <= (state_q == MD_FIX);
            if (accept) begin
                a_q  <= md.a;
                b_q  <= md.b;
                op_q <= md_op_e'(md.op);
            end
            case (state_q)
                MD_IDLE: begin
                    cnt_q <= '0;
                    if (md.hi_we) hi_q <= md.wd;
                    if (md.lo_we) lo_q <= md.wd;
                end
                MD_LOAD: begin
                    acc_q    <= '0;
                    neg_lo_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                    mq_q     <= is_div ? abs_a : abs_b;
                    opnd_q   <= is_div ? abs_b : abs_a;
                    neg_hi_q <= is_signed & a_q[WIDTH-1];
                    div0_q   <= (b_q == '0);
`else
                    mq_q     <= abs_b;
                    opnd_q   <= abs_a;
`endif
                end
                MD_RUN: begin
                    acc_q <= acc_nx;
                    mq_q  <= mq_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                MD_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
